// File: rtl/cpu_types_pkg.sv
// Shared processor-side types for the memory arbiter and related blocks.
//   ramstate_t  : state reported by the cpu_ram_if RAM port
//   arb_state_t : arbiter FSM state
//   word_t      : 32-bit data word
//   CORE*_I/_D  : requester indices (core0 I, core0 D, core1 I, core1 D)
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Prefixed so the literals do not collide with ramstate_t::BUSY.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef logic [31:0] word_t;

    localparam int CORE0_I = 0;
    localparam int CORE0_D = 1;
    localparam int CORE1_I = 2;
    localparam int CORE1_D = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set bit of req,
// scanning from last+1 and wrapping at NREQ-1 (works for any NREQ >= 2,
// not just powers of two).
// Ports:
//   req   in  NREQ  request vector
//   last  in  GW    index served most recently
//   hit   out 1     at least one request present
//   index out GW    winning requester index (0 when no hit)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last,
    output logic            hit,
    output logic [GW-1:0]   index
);

    logic [GW-1:0] cand_s;

    // Walk the candidates in round-robin order, keep the first one requesting.
    always_comb begin
        hit    = 1'b0;
        index  = '0;
        cand_s = last;
        for (int i = 0; i < NREQ; i++) begin
            if (cand_s == GW'(NREQ - 1)) begin
                cand_s = '0;
            end else begin
                cand_s = cand_s + GW'(1);
            end
            if (!hit && req[cand_s]) begin
                hit   = 1'b1;
                index = cand_s;
            end else begin
                hit   = hit;
                index = index;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between NREQ cache requesters and a single RAM port.
// One transaction outstanding at a time; an IDLE arbitration cycle precedes
// every grant.
// Optional feature macro: ARB_TIMEOUT_EN -- abort a grant that sits in BUSY
// for TIMEOUT cycles without ACCESS/ERROR (raises arb_err).
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   req_ren/req_wen      per-requester read/write request (NREQ)
//   req_addr/req_store   per-requester address / write data
//   req_wait             per-requester hold indication
//   req_load             read data (valid in the completion cycle)
//   memREN/memWEN        RAM enables
//   memaddr/memstore     RAM address / write data
//   ramload, ramstate    RAM read data and status
//   arb_err              one-cycle pulse on an aborted transaction
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NREQ-1:0]          req_ren,
    input  logic [NREQ-1:0]          req_wen,
    input  logic [NREQ-1:0][AW-1:0]  req_addr,
    input  logic [NREQ-1:0][DW-1:0]  req_store,
    output logic [NREQ-1:0]          req_wait,
    output logic [DW-1:0]            req_load,
    output logic                     memREN,
    output logic                     memWEN,
    output logic [AW-1:0]            memaddr,
    output logic [DW-1:0]            memstore,
    input  logic [DW-1:0]            ramload,
    input  ramstate_t                ramstate,
    output logic                     arb_err
);

    localparam int GW = $clog2(NREQ);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("TIMEOUT must fit the 8-bit BUSY counter");
    end

    arb_state_t      state_r;
    logic [GW-1:0]   grant_r;
    logic [GW-1:0]   last_r;

    logic [NREQ-1:0] active_s;
    logic            pick_hit_s;
    logic [GW-1:0]   pick_idx_s;
    logic            busy_s;
    logic            ren_g_s;
    logic            wen_g_s;
    logic            held_s;
    logic            timeout_s;
    logic            done_s;
    logic            err_s;

    assign active_s = req_ren | req_wen;

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .req   (active_s),
        .last  (last_r),
        .hit   (pick_hit_s),
        .index (pick_idx_s)
    );

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_r;
    assign timeout_s = (cnt_r == 8'(TIMEOUT));

    // BUSY-cycle counter: cleared on grant, counts cycles without completion.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_r <= 8'd0;
        end else if (state_r == ARB_IDLE) begin
            cnt_r <= 8'd0;
        end else if (!done_s) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Decode the granted requester and the completion/abort conditions.
    // A requester that drops its request wins over ERROR/timeout: silent abort.
    always_comb begin
        busy_s  = (state_r == ARB_BUSY);
        ren_g_s = req_ren[grant_r];
        wen_g_s = req_wen[grant_r];
        held_s  = ren_g_s | wen_g_s;
        err_s   = busy_s && held_s && ((ramstate == ERROR) || timeout_s);
        done_s  = busy_s && held_s && ((ramstate == ACCESS) || (ramstate == ERROR) || timeout_s);
    end

    // RAM-side and requester-side outputs; write takes priority over read.
    always_comb begin
        req_wait = active_s;
        memREN   = 1'b0;
        memWEN   = 1'b0;
        memaddr  = '0;
        memstore = '0;
        if (busy_s) begin
            memREN   = ren_g_s & ~wen_g_s;
            memWEN   = wen_g_s;
            memaddr  = req_addr[grant_r];
            memstore = req_store[grant_r];
        end else begin
            memREN   = 1'b0;
        end
        if (done_s) begin
            req_wait[grant_r] = 1'b0;
        end else begin
            req_wait = req_wait;
        end
    end

    assign req_load = ramload;
    assign arb_err  = err_s;

    // Arbiter FSM: IDLE picks the next requester, BUSY waits for completion.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ARB_IDLE;
            grant_r <= '0;
            last_r  <= GW'(NREQ - 1);
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (pick_hit_s) begin
                        grant_r <= pick_idx_s;
                        state_r <= ARB_BUSY;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_BUSY: begin
                    if (!held_s) begin
                        state_r <= ARB_IDLE;
                    end else if (done_s) begin
                        last_r  <= grant_r;
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_BUSY;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vector table plus
// hand-written reset-mid-BUSY and BUSY-hold sequences.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

`ifdef ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic [3:0]       req_ren = 4'd0;
    logic [3:0]       req_wen = 4'd0;
    logic [3:0][31:0] req_addr;
    logic [3:0][31:0] req_store;
    logic [3:0]       req_wait;
    logic [31:0]      req_load;
    logic             memREN;
    logic             memWEN;
    logic [31:0]      memaddr;
    logic [31:0]      memstore;
    logic [31:0]      ramload = 32'd0;
    ramstate_t        ramstate = FREE;
    logic             arb_err;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.NREQ(4), .AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req_ren   (req_ren),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_store (req_store),
        .req_wait  (req_wait),
        .req_load  (req_load),
        .memREN    (memREN),
        .memWEN    (memWEN),
        .memaddr   (memaddr),
        .memstore  (memstore),
        .ramload   (ramload),
        .ramstate  (ramstate),
        .arb_err   (arb_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  ren;
        logic [3:0]  wen;
        ramstate_t   rs;
        logic [31:0] rload;
        logic [3:0]  wt;
        logic        mren;
        logic        mwen;
        logic [31:0] maddr;
        logic [31:0] mstore;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] A0 = 32'h0000_0004;
    localparam logic [31:0] A1 = 32'h0000_0100;
    localparam logic [31:0] A2 = 32'h0000_0200;
    localparam logic [31:0] A3 = 32'h0000_0300;
    localparam logic [31:0] S0 = 32'hA0A0_0000;
    localparam logic [31:0] S1 = 32'h1234_5678;
    localparam logic [31:0] S2 = 32'hA0A0_0002;
    localparam logic [31:0] S3 = 32'hA0A0_0003;
    localparam logic [31:0] Z  = 32'h0000_0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one row, check combinational outputs mid-cycle, then clock it.
    task automatic apply(input vec_t v, input int n);
        req_ren  = v.ren;
        req_wen  = v.wen;
        ramstate = v.rs;
        ramload  = v.rload;
        #2;
        chk($sformatf("row%0d wait", n),  32'(req_wait), 32'(v.wt));
        chk($sformatf("row%0d ren", n),   32'(memREN),   32'(v.mren));
        chk($sformatf("row%0d wen", n),   32'(memWEN),   32'(v.mwen));
        chk($sformatf("row%0d addr", n),  memaddr,       v.maddr);
        chk($sformatf("row%0d store", n), memstore,      v.mstore);
        chk($sformatf("row%0d err", n),   32'(arb_err),  32'(v.err));
        chk($sformatf("row%0d load", n),  req_load,      v.rload);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int first_err;
        int err_cnt;

        req_addr  = {A3, A2, A1, A0};
        req_store = {S3, S2, S1, S0};

        // Single read from requester 0, 2-cycle RAM latency.
        vecs.push_back('{4'b0001, 4'b0000, FREE,   Z,            4'b0001, 1'b0, 1'b0, Z,  Z,  1'b0});
        vecs.push_back('{4'b0001, 4'b0000, BUSY,   Z,            4'b0001, 1'b1, 1'b0, A0, S0, 1'b0});
        vecs.push_back('{4'b0001, 4'b0000, BUSY,   Z,            4'b0001, 1'b1, 1'b0, A0, S0, 1'b0});
        vecs.push_back('{4'b0001, 4'b0000, ACCESS, 32'hDEAD_BEEF, 4'b0000, 1'b1, 1'b0, A0, S0, 1'b0});
        vecs.push_back('{4'b0000, 4'b0000, FREE,   Z,            4'b0000, 1'b0, 1'b0, Z,  Z,  1'b0});
        // ren and wen together on requester 1: write wins.
        vecs.push_back('{4'b0010, 4'b0010, FREE,   Z,            4'b0010, 1'b0, 1'b0, Z,  Z,  1'b0});
        vecs.push_back('{4'b0010, 4'b0010, ACCESS, Z,            4'b0000, 1'b0, 1'b1, A1, S1, 1'b0});
        vecs.push_back('{4'b0000, 4'b0000, FREE,   Z,            4'b0000, 1'b0, 1'b0, Z,  Z,  1'b0});
        // ERROR on requester 2, then requester 3 is served next.
        vecs.push_back('{4'b1100, 4'b0000, FREE,   Z,            4'b1100, 1'b0, 1'b0, Z,  Z,  1'b0});
        vecs.push_back('{4'b1100, 4'b0000, ERROR,  Z,            4'b1000, 1'b1, 1'b0, A2, S2, 1'b1});
        vecs.push_back('{4'b1000, 4'b0000, FREE,   Z,            4'b1000, 1'b0, 1'b0, Z,  Z,  1'b0});
        vecs.push_back('{4'b1000, 4'b0000, ACCESS, Z,            4'b0000, 1'b1, 1'b0, A3, S3, 1'b0});
        vecs.push_back('{4'b0000, 4'b0000, FREE,   Z,            4'b0000, 1'b0, 1'b0, Z,  Z,  1'b0});
        // All four held: grants 0,1,2,3,0 with an IDLE cycle between each.
        vecs.push_back('{4'b1111, 4'b0000, FREE,   Z,            4'b1111, 1'b0, 1'b0, Z,  Z,  1'b0});
        vecs.push_back('{4'b1111, 4'b0000, ACCESS, 32'h0000_1000, 4'b1110, 1'b1, 1'b0, A0, S0, 1'b0});
        vecs.push_back('{4'b1111, 4'b0000, FREE,   Z,            4'b1111, 1'b0, 1'b0, Z,  Z,  1'b0});
        vecs.push_back('{4'b1111, 4'b0000, ACCESS, 32'h0000_1001, 4'b1101, 1'b1, 1'b0, A1, S1, 1'b0});
        vecs.push_back('{4'b1111, 4'b0000, FREE,   Z,            4'b1111, 1'b0, 1'b0, Z,  Z,  1'b0});
        vecs.push_back('{4'b1111, 4'b0000, ACCESS, 32'h0000_1002, 4'b1011, 1'b1, 1'b0, A2, S2, 1'b0});
        vecs.push_back('{4'b1111, 4'b0000, FREE,   Z,            4'b1111, 1'b0, 1'b0, Z,  Z,  1'b0});
        vecs.push_back('{4'b1111, 4'b0000, ACCESS, 32'h0000_1003, 4'b0111, 1'b1, 1'b0, A3, S3, 1'b0});
        vecs.push_back('{4'b1111, 4'b0000, FREE,   Z,            4'b1111, 1'b0, 1'b0, Z,  Z,  1'b0});
        vecs.push_back('{4'b1111, 4'b0000, ACCESS, 32'h0000_1004, 4'b1110, 1'b1, 1'b0, A0, S0, 1'b0});
        vecs.push_back('{4'b0000, 4'b0000, FREE,   Z,            4'b0000, 1'b0, 1'b0, Z,  Z,  1'b0});
        // Requester 2 drops mid-BUSY: silent abort, last stays 0 so 1 wins over 3.
        vecs.push_back('{4'b0100, 4'b0000, FREE,   Z,            4'b0100, 1'b0, 1'b0, Z,  Z,  1'b0});
        vecs.push_back('{4'b0100, 4'b0000, BUSY,   Z,            4'b0100, 1'b1, 1'b0, A2, S2, 1'b0});
        vecs.push_back('{4'b0000, 4'b0000, BUSY,   Z,            4'b0000, 1'b0, 1'b0, A2, S2, 1'b0});
        vecs.push_back('{4'b1010, 4'b0000, FREE,   Z,            4'b1010, 1'b0, 1'b0, Z,  Z,  1'b0});
        vecs.push_back('{4'b1010, 4'b0000, ACCESS, 32'h0000_2001, 4'b1000, 1'b1, 1'b0, A1, S1, 1'b0});
        vecs.push_back('{4'b0000, 4'b0000, FREE,   Z,            4'b0000, 1'b0, 1'b0, Z,  Z,  1'b0});

        // Reset state, with requests present to show nothing leaks through.
        req_ren = 4'b1111;
        repeat (2) @(posedge CLK);
        #2;
        chk("rst memREN",   32'(memREN),  32'd0);
        chk("rst memWEN",   32'(memWEN),  32'd0);
        chk("rst memaddr",  memaddr,      32'd0);
        chk("rst memstore", memstore,     32'd0);
        chk("rst arb_err",  32'(arb_err), 32'd0);
        req_ren = 4'b0000;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Reset pulsed mid-BUSY: enables must drop with no clock edge.
        req_ren  = 4'b0100;
        ramstate = FREE;
        @(posedge CLK);
        #1;
        ramstate = BUSY;
        #2;
        chk("midrst busy memREN", 32'(memREN), 32'd1);
        nRST = 1'b0;
        #1;
        chk("midrst memREN", 32'(memREN), 32'd0);
        chk("midrst memWEN", 32'(memWEN), 32'd0);
        chk("midrst wait",   32'(req_wait), 32'b0100);
        @(negedge CLK);
        nRST     = 1'b1;
        req_ren  = 4'b1111;
        ramstate = FREE;
        @(posedge CLK);
        #1;
        ramstate = ACCESS;
        #2;
        chk("postrst grant addr", memaddr, A0);
        chk("postrst memREN",     32'(memREN), 32'd1);
        chk("postrst wait",       32'(req_wait), 32'b1110);
        @(posedge CLK);
        #1;
        req_ren  = 4'b0000;
        ramstate = FREE;
        @(posedge CLK);
        #1;

        // RAM held in BUSY on a grant to requester 3.
        req_ren = 4'b1000;
        @(posedge CLK);
        #1;
        ramstate  = BUSY;
        first_err = -1;
        err_cnt   = 0;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 20 && first_err < 0; k++) begin
            #2;
            if (arb_err) begin
                first_err = k;
                chk("timeout wait", 32'(req_wait), 32'd0);
            end
            @(posedge CLK);
            #1;
        end
        chk("timeout cycle", 32'(first_err), 32'd8);
        #2;
        chk("timeout idle memREN", 32'(memREN), 32'd0);
        chk("timeout idle err",    32'(arb_err), 32'd0);
`else
        for (int k = 0; k < 300; k++) begin
            #2;
            if (arb_err) begin
                err_cnt++;
            end
            @(posedge CLK);
            #1;
        end
        #2;
        chk("hold err pulses", 32'(err_cnt), 32'd0);
        chk("hold memREN",     32'(memREN),  32'd1);
        chk("hold memaddr",    memaddr,      A3);
        chk("hold wait",       32'(req_wait), 32'b1000);
`endif
        req_ren  = 4'b0000;
        ramstate = FREE;
        @(posedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
